// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared digit limits and BCD type for the timekeeper
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_TEN_MAX       = 5;
  localparam int MIN_TEN_MAX       = 5;
  localparam int ONE_MAX           = 9;
  localparam int HOUR_TEN_MAX      = 2;
  localparam int HOUR_ONE_MAX_AT_2 = 3;

endpackage

// File: rtl/bcd_pair_counter.sv
// rtl/bcd_pair_counter.sv - two-digit BCD counter with configurable wrap point
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int TEN_MAX     = 5,
  parameter int ONE_MAX     = 9,
  // ones limit that applies only when the tens digit is at TEN_MAX (hours stop at 23)
  parameter int TOP_ONE_MAX = ONE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output bcd_t o_ten,
  output bcd_t o_one,
  output logic o_wrap
);

  bcd_t r_ten;
  bcd_t r_one;
  logic w_top;
  logic w_at_max;

  assign w_top    = (r_ten >= bcd_t'(TEN_MAX));
  assign w_at_max = w_top && (r_one >= bcd_t'(TOP_ONE_MAX));
  assign o_wrap   = i_inc & w_at_max;
  assign o_ten    = r_ten;
  assign o_one    = r_one;

  // Advance the pair; any out-of-range digit collapses to 0 on its next update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ten <= '0;
      r_one <= '0;
    end else if (i_clr) begin
      r_ten <= '0;
      r_one <= '0;
    end else if (i_inc) begin
      if (w_at_max || r_ten > bcd_t'(TEN_MAX)) begin
        r_ten <= '0;
        r_one <= '0;
      end else if (r_one >= bcd_t'(ONE_MAX)) begin
        r_one <= '0;
        r_ten <= w_top ? '0 : r_ten + 4'd1;
      end else begin
        r_one <= r_one + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// rtl/clock_timekeeper.sv - 24-hour BCD time-of-day counter with set mode
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_set,
  input  logic       btn_min,
  input  logic       btn_hour,
  input  logic       btn_sec_clr,
  output logic [3:0] h_ten,
  output logic [3:0] h_one,
  output logic [3:0] m_ten,
  output logic [3:0] m_one,
  output logic [3:0] s_ten,
  output logic [3:0] s_one,
  output logic       sec_pulse,
  output logic       min_pulse
);

  logic [CNT_W-1:0] r_prescaler;
  logic             r_prev_min;
  logic             r_prev_hour;
  logic             r_prev_sec_clr;
  logic             r_sec_pulse;
  logic             r_min_pulse;

  logic w_tick;
  logic w_pulse_min;
  logic w_pulse_hour;
  logic w_pulse_sec_clr;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;
  logic w_min_inc;
  logic w_hour_inc;

  // enable_set takes priority over a pending tick
  assign w_tick = !enable_set && (r_prescaler == CNT_W'(CLK_DIV - 1));

  assign w_pulse_min     = enable_set & btn_min     & ~r_prev_min;
  assign w_pulse_hour    = enable_set & btn_hour    & ~r_prev_hour;
  assign w_pulse_sec_clr = enable_set & btn_sec_clr & ~r_prev_sec_clr;

  // Set-mode increments never carry: the carry chain is gated by the tick.
  assign w_min_inc  = (w_tick & w_sec_wrap) | w_pulse_min;
  assign w_hour_inc = (w_tick & w_sec_wrap & w_min_wrap) | w_pulse_hour;

  // Prescaler: free-runs in run mode, parked at 0 while setting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler <= '0;
    end else if (enable_set || w_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + CNT_W'(1);
    end
  end

  // Button history always tracks, even when presses are being ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_min     <= 1'b0;
      r_prev_hour    <= 1'b0;
      r_prev_sec_clr <= 1'b0;
    end else begin
      r_prev_min     <= btn_min;
      r_prev_hour    <= btn_hour;
      r_prev_sec_clr <= btn_sec_clr;
    end
  end

  // Strobes line up with the digits they announce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_pulse <= 1'b0;
      r_min_pulse <= 1'b0;
    end else begin
      r_sec_pulse <= w_tick;
      r_min_pulse <= w_tick & w_sec_wrap;
    end
  end

  bcd_pair_counter #(
    .TEN_MAX (SEC_TEN_MAX),
    .ONE_MAX (ONE_MAX)
  ) u_sec (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_tick),
    .i_clr  (w_pulse_sec_clr),
    .o_ten  (s_ten),
    .o_one  (s_one),
    .o_wrap (w_sec_wrap)
  );

  bcd_pair_counter #(
    .TEN_MAX (MIN_TEN_MAX),
    .ONE_MAX (ONE_MAX)
  ) u_min (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_min_inc),
    .i_clr  (1'b0),
    .o_ten  (m_ten),
    .o_one  (m_one),
    .o_wrap (w_min_wrap)
  );

  bcd_pair_counter #(
    .TEN_MAX     (HOUR_TEN_MAX),
    .ONE_MAX     (ONE_MAX),
    .TOP_ONE_MAX (HOUR_ONE_MAX_AT_2)
  ) u_hour (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_hour_inc),
    .i_clr  (1'b0),
    .o_ten  (h_ten),
    .o_one  (h_one),
    .o_wrap (w_hour_wrap)
  );

  assign sec_pulse = r_sec_pulse;
  assign min_pulse = r_min_pulse;

  // End of day needs no consumer here.
  logic w_unused;
  assign w_unused = w_hour_wrap;

endmodule

// File: tb/tb_clock_timekeeper.sv
// tb/tb_clock_timekeeper.sv - self-checking bench for clock_timekeeper
module tb_clock_timekeeper;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_set;
  logic       btn_min;
  logic       btn_hour;
  logic       btn_sec_clr;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic       sec_pulse;
  logic       min_pulse;

  clock_timekeeper #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_set  (enable_set),
    .btn_min     (btn_min),
    .btn_hour    (btn_hour),
    .btn_sec_clr (btn_sec_clr),
    .h_ten       (h_ten),
    .h_one       (h_one),
    .m_ten       (m_ten),
    .m_one       (m_one),
    .s_ten       (s_ten),
    .s_one       (s_one),
    .sec_pulse   (sec_pulse),
    .min_pulse   (min_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: time of day as seconds since midnight
  int m_t;
  int m_presc;
  bit m_prev_min, m_prev_hour, m_prev_clr;
  bit e_sp, e_mp;
  int sp_count, mp_count;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd_of(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return ((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
           ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic int dut_time();
    return int'({h_ten, h_one, m_ten, m_one, s_ten, s_one});
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_presc = 0;
    m_prev_min = 0;
    m_prev_hour = 0;
    m_prev_clr = 0;
    e_sp = 0;
    e_mp = 0;
  endtask

  task automatic model_step();
    bit pm, ph, pc;
    int h, m, s;
    pm = btn_min && !m_prev_min;
    ph = btn_hour && !m_prev_hour;
    pc = btn_sec_clr && !m_prev_clr;
    m_prev_min = btn_min;
    m_prev_hour = btn_hour;
    m_prev_clr = btn_sec_clr;
    e_sp = 0;
    e_mp = 0;
    if (enable_set) begin
      m_presc = 0;
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      s = m_t % 60;
      if (pm) m = (m + 1) % 60;
      if (ph) h = (h + 1) % 24;
      if (pc) s = 0;
      m_t = h * 3600 + m * 60 + s;
    end else if (m_presc == CLK_DIV - 1) begin
      m_presc = 0;
      e_sp = 1;
      e_mp = (m_t % 60 == 59);
      m_t = (m_t + 1) % 86400;
    end else begin
      m_presc++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check("time", dut_time(), bcd_of(m_t));
    check("sec_pulse", int'(sec_pulse), int'(e_sp));
    check("min_pulse", int'(min_pulse), int'(e_mp));
    sp_count += int'(sec_pulse);
    mp_count += int'(min_pulse);
  endtask

  task automatic press(input bit bm, input bit bh, input bit bc);
    btn_min = bm;
    btn_hour = bh;
    btn_sec_clr = bc;
    cycle();
    btn_min = 0;
    btn_hour = 0;
    btn_sec_clr = 0;
    cycle();
  endtask

  task automatic set_time(input int h, input int m);
    enable_set = 1;
    cycle();
    while (m_t / 3600 != h) press(0, 1, 0);
    while ((m_t / 60) % 60 != m) press(1, 0, 0);
    press(0, 0, 1);
    enable_set = 0;
  endtask

  initial begin
    int hour_before;
    rst = 1;
    enable_set = 0;
    btn_min = 0;
    btn_hour = 0;
    btn_sec_clr = 0;
    sp_count = 0;
    mp_count = 0;
    model_reset();
    cycle();
    cycle();
    rst = 0;

    // free run from reset: three seconds in 3*CLK_DIV cycles
    sp_count = 0;
    mp_count = 0;
    repeat (3 * CLK_DIV) cycle();
    check("run3_time", dut_time(), 'h000003);
    check("run3_sp_count", sp_count, 3);
    check("run3_mp_count", mp_count, 0);

    // end-of-day rollover
    set_time(23, 59);
    mp_count = 0;
    repeat (60 * CLK_DIV) cycle();
    check("eod_time", dut_time(), 'h000000);
    check("eod_mp_count", mp_count, 1);

    // 61 minute presses: wrap without touching hours
    enable_set = 1;
    cycle();
    sp_count = 0;
    repeat (61) press(1, 0, 0);
    check("min61_time", dut_time(), 'h000100);
    check("min61_sp_count", sp_count, 0);

    // simultaneous buttons at 09:30:27
    set_time(9, 30);
    repeat (27 * CLK_DIV) cycle();
    check("pre_sim_time", dut_time(), 'h093027);
    enable_set = 1;
    cycle();
    btn_min = 1;
    btn_hour = 1;
    btn_sec_clr = 1;
    cycle();
    check("sim_time", dut_time(), 'h103100);
    repeat (3) cycle();
    check("sim_hold_time", dut_time(), 'h103100);
    btn_min = 0;
    btn_hour = 0;
    btn_sec_clr = 0;
    cycle();

    // hour button held across entry into set mode
    enable_set = 0;
    btn_hour = 1;
    repeat (3) cycle();
    enable_set = 1;
    hour_before = m_t / 3600;
    repeat (3) cycle();
    check("held_hour", int'({h_ten, h_one}), ((hour_before / 10) << 4) | (hour_before % 10));
    btn_hour = 0;
    cycle();
    btn_hour = 1;
    cycle();
    check("repress_hour", int'({h_ten, h_one}),
          ((((hour_before + 1) % 24) / 10) << 4) | (((hour_before + 1) % 24) % 10));
    btn_hour = 0;
    cycle();

    // asynchronous reset mid-second
    set_time(12, 34);
    repeat (56 * CLK_DIV) cycle();
    check("pre_rst_time", dut_time(), 'h123456);
    repeat (2) cycle();
    rst = 1;
    #1;
    check("async_rst_time", dut_time(), 'h000000);
    check("async_rst_sp", int'(sec_pulse), 0);
    model_reset();
    cycle();
    rst = 0;
    sp_count = 0;
    repeat (CLK_DIV - 1) cycle();
    check("post_rst_no_tick", sp_count, 0);
    cycle();
    check("post_rst_first_tick", sp_count, 1);

    // randomized mix of run and set activity
    repeat (4000) begin
      if ($urandom_range(0, 59) == 0) enable_set = ~enable_set;
      if ($urandom_range(0, 3) == 0) btn_min = ~btn_min;
      if ($urandom_range(0, 4) == 0) btn_hour = ~btn_hour;
      if ($urandom_range(0, 9) == 0) btn_sec_clr = ~btn_sec_clr;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
24-hour BCD timekeeping core for the digital clock. It divides the system clock down to 1 Hz and counts hours, minutes and seconds as six BCD digits. It also provides a set mode for manual adjustment. The digits feed the alarm comparator, the display mux and any other time consumers; the block is the sole source of the current time.

Parameters:
CLK_DIV, 50_000_000, system clock cycles per second tick; minimum 2. Benches use 4.
CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= CLK_DIV.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable_set  in  1  level; 1 = time-set mode, counting paused
btn_min  in  1  debounced level; rising edge increments minutes in set mode
btn_hour  in  1  debounced level; rising edge increments hours in set mode
btn_sec_clr  in  1  debounced level; rising edge zeroes seconds in set mode
h_ten  out  4  hours tens, BCD 0..2
h_one  out  4  hours ones, BCD 0..9 (0..3 when h_ten=2)
m_ten  out  4  minutes tens, 0..5
m_one  out  4  minutes ones, 0..9
s_ten  out  4  seconds tens, 0..5
s_one  out  4  seconds ones, 0..9
sec_pulse  out  1  one-cycle strobe, high in the cycle the new second value is first visible
min_pulse  out  1  one-cycle strobe, high when seconds wrap 59->00 by counting (not by set)

Behaviour:
- Reset (async assert, sync use after deassert): all digits 0 (00:00:00), sec_pulse=0, min_pulse=0, prescaler=0, button history regs=0.
- Button one-shots: prev_x registered every clk; pulse_x = btn_x & ~prev_x. A button held through reset release yields one pulse on the first clock after reset.
- Prescaler (run mode, enable_set=0): counts 0..CLK_DIV-1. tick = (prescaler == CLK_DIV-1). On a tick edge, prescaler returns to 0 and the time advances by one second on the same edge.
- sec_pulse/min_pulse are registered. They are asserted in the cycle after that tick edge, coincident with the updated digits.
- Cascade on tick:
  - s_one 9->0 carries into s_ten; s_ten 5 with s_one 9 -> 00 and carries to minutes.
  - Minutes wrap 59->00 the same way, carrying to hours.
  - Hours wrap 23->00; ones 9->0 increments h_ten.
  - 23:59:59 + tick -> 00:00:00 in one edge.
- All carries resolve in the same edge; no intermediate value is ever visible.
- Set mode (enable_set=1):
  - Prescaler held at 0 and no ticks occur, so sec_pulse and min_pulse stay 0.
  - pulse_min: minutes +1, 59->00 with no carry into hours.
  - pulse_hour: hours +1, 23->00.
  - pulse_sec_clr: s_ten=s_one=0.
  - Simultaneous pulses all apply on the same edge, independently.
  - Button pulses are ignored when enable_set=0, but history regs still track.
- Leaving set mode: prescaler starts from 0, so the first tick occurs CLK_DIV cycles after the first run-mode edge.
- Entering set mode on a tick edge: enable_set is sampled first. If enable_set=1 on that edge, no tick is taken and the prescaler clears.
- Digits are always legal BCD; no reachable illegal states. A defensive default returns any illegal digit to 0 on its next update.

Decomposition:
- Shared package clock_pkg: constants SEC_TEN_MAX=5, MIN_TEN_MAX=5, ONE_MAX=9, HOUR_TEN_MAX=2, HOUR_ONE_MAX_AT_2=3; typedef bcd_t (4-bit logic).
- One natural sub-module, bcd_pair_counter: two-digit BCD counter with parameters TEN_MAX/ONE_MAX and inputs inc, clr. It outputs wrap = inc & at_max.
  - Used for seconds and minutes.
  - Hours uses it with ONE_MAX override logic (23 limit) or a local instance variant.
- Button one-shots stay inline.

Test Plan:
- Reset then run 3*CLK_DIV cycles (CLK_DIV=4) -> digits 00:00:03; sec_pulse high exactly 3 cycles, spaced 4 apart; min_pulse never high.
- Preload via set mode to 23:59:00, then run 60 ticks -> 00:00:00 on the 60th tick edge; min_pulse single-cycle with it; no intermediate 23:59:60 or 24:00:00 seen.
- enable_set=1; pulse btn_min 61 times -> minutes 00->59->00->01; hours unchanged; seconds frozen; no sec_pulse.
- enable_set=1 with time 09:30:27; raise btn_hour, btn_min and btn_sec_clr on the same cycle -> 10:31:00 next cycle; holding the buttons gives no further change.
- Hold btn_hour high with enable_set=0, then raise enable_set -> no increment; a later release/press -> +1 hour.
- Assert rst mid-tick (prescaler=2) at 12:34:56 -> immediate 00:00:00; first tick CLK_DIV cycles after release.
